// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               controller: controller state enum, stall bus patterns and
//               the default exception vector.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Stall bus patterns: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage
`default_nettype wire

// File: rtl/stall_encoder.sv
`default_nettype none
// ============================================================================
// Module      : stall_encoder
// Description : Combinational priority encoder from the four stage stall
//               requests to the shared stall bus. The most downstream
//               requesting stage wins; it is held together with every stage
//               upstream of it.
// Ports       : stallreq_if/id/ex/mem - per-stage stall requests
//               stall                 - encoded per-stage hold bus
// Revision    : 1.0 - initial release
// ============================================================================
module stall_encoder
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W = 6
) (
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  output logic [STALL_W-1:0] stall
);

  always_comb begin
    stall = STALL_W'(STALL_NONE);
    if (stallreq_mem) begin
      stall = STALL_W'(STALL_MEM);
    end else if (stallreq_ex) begin
      stall = STALL_W'(STALL_EX);
    end else if (stallreq_id) begin
      stall = STALL_W'(STALL_ID);
    end else if (stallreq_if) begin
      stall = STALL_W'(STALL_IF);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central stall/flush controller for the five-stage pipeline.
//               Drives the shared stall bus, sequences precise exceptions and
//               eret raised in MEM (freeze, flush, redirect) and keeps stall
//               and flush performance counters.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               stallreq_*            - per-stage stall requests
//               excp_valid/eret_valid - redirect requests from MEM
//               cp0_epc               - eret return address
//               perf_clr              - clear both counters
//               stall, flush          - pipeline register controls
//               new_pc, new_pc_valid  - PC redirect
//               stall_cnt, flush_cnt  - saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               excp_valid,
  input  logic               eret_valid,
  input  logic [31:0]        cp0_epc,
  input  logic               perf_clr,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               new_pc_valid,
  output logic [31:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  state_e             state_q, state_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic [15:0]        flush_cnt_q, flush_cnt_d;
  logic [STALL_W-1:0] stall_enc;
  logic               req;
  logic [31:0]        req_tgt;

  stall_encoder #(
    .STALL_W (STALL_W)
  ) u_stall_encoder (
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .stall        (stall_enc)
  );

  // Exception wins over eret when both are raised together.
  assign req     = excp_valid | eret_valid;
  assign req_tgt = excp_valid ? EXC_VECTOR : cp0_epc;

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    stall        = stall_enc;
    flush        = 1'b0;
    new_pc_valid = 1'b0;

    case (state_q)
      RUN: begin
        if (req) begin
          tgt_d   = req_tgt;
          stall   = STALL_W'(STALL_ALL);
          // An outstanding bus transaction must finish before the flush.
          state_d = stallreq_mem ? PEND : FLUSH;
        end
      end
      PEND: begin
        stall = STALL_W'(STALL_ALL);
        if (!stallreq_mem) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Requests are ignored: their source instructions are being flushed.
        stall        = STALL_W'(STALL_NONE);
        flush        = 1'b1;
        new_pc_valid = 1'b1;
        state_d      = RUN;
      end
      default: begin
        stall   = STALL_W'(STALL_NONE);
        state_d = RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((state_q == RUN) && stall[0] && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_q != FLUSH) && (state_d == FLUSH) && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign new_pc    = tgt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl: stall encoding table,
//               directed redirect sequences and randomized traffic against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        sr_if, sr_id, sr_ex, sr_mem;
  logic        excp, eret, perf_clr;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush, npv;
  logic [31:0] new_pc, stall_cnt;
  logic [15:0] flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (sr_if),
    .stallreq_id  (sr_id),
    .stallreq_ex  (sr_ex),
    .stallreq_mem (sr_mem),
    .excp_valid   (excp),
    .eret_valid   (eret),
    .cp0_epc      (epc),
    .perf_clr     (perf_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .new_pc_valid (npv),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: redirect bookkeeping as simple flags.
  bit          m_flush;   // this cycle is the one-cycle flush
  bit          m_pend;    // waiting for the bus to finish
  logic [31:0] m_tgt;
  logic [31:0] m_scnt;
  logic [15:0] m_fcnt;

  function automatic logic [5:0] exp_stall();
    int n;
    if (m_flush) return 6'd0;
    if (m_pend || excp || eret) return 6'h3F;
    // Number of held stages (pc plus upstream stages of the winner).
    n = sr_mem ? 5 : sr_ex ? 4 : sr_id ? 3 : sr_if ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic set_in(input bit f, input bit d, input bit x, input bit m,
                        input bit e, input bit r, input logic [31:0] pc,
                        input bit clr);
    sr_if = f; sr_id = d; sr_ex = x; sr_mem = m;
    excp = e; eret = r; epc = pc; perf_clr = clr;
  endtask

  // Called at a negedge with inputs applied; compares, advances the model
  // on the posedge and returns at the next negedge.
  task automatic cycle();
    logic [5:0] es;
    bit run, req, go_flush, go_pend;
    #1;
    es = exp_stall();
    chk("stall", 32'(stall), 32'(es));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc_valid", 32'(npv), 32'(m_flush));
    chk("new_pc", new_pc, m_tgt);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    @(posedge clk);
    run = !m_flush && !m_pend;
    req = excp || eret;
    if (rst) begin
      m_flush = 0; m_pend = 0; m_tgt = '0; m_scnt = '0; m_fcnt = '0;
    end else begin
      go_flush = (run && req && !sr_mem) || (m_pend && !sr_mem);
      go_pend  = (run && req && sr_mem) || (m_pend && sr_mem);
      if (run && req) m_tgt = excp ? VEC : epc;
      if (perf_clr) begin
        m_scnt = '0;
        m_fcnt = '0;
      end else begin
        if (run && es[0] && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (go_flush && m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 1;
      end
      m_flush = go_flush;
      m_pend  = go_pend;
    end
    @(negedge clk);
  endtask

  typedef struct packed {
    logic       f, d, x, m;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          base, nz;
    logic [31:0] rpc;

    tbl[0] = {1'b1, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[1] = {1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    tbl[2] = {1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
    tbl[3] = {1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[4] = {1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    tbl[5] = {1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
    tbl[6] = {1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};
    tbl[7] = {1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};

    m_flush = 0; m_pend = 0; m_tgt = '0; m_scnt = '0; m_fcnt = '0;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_npv", 32'(npv), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    @(negedge clk);

    // Stall encoding table.
    base = int'(stall_cnt);
    nz   = 0;
    for (int k = 0; k < 8; k++) begin
      set_in(tbl[k].f, tbl[k].d, tbl[k].x, tbl[k].m, 0, 0, 32'h0, 0);
      if (tbl[k].exp != 6'd0) nz++;
      #1;
      chk("enc_tbl", 32'(stall), 32'(tbl[k].exp));
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("enc_stall_cnt_delta", stall_cnt, 32'(base + nz));
    @(negedge clk);

    // Plain exception.
    set_in(0, 0, 0, 0, 1, 0, 32'h0, 0);
    #1; chk("exc_accept_stall", 32'(stall), 32'h3F); chk("exc_accept_flush", 32'(flush), 32'h0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("exc_flush", 32'(flush), 32'h1);
    chk("exc_npv", 32'(npv), 32'h1);
    chk("exc_new_pc", new_pc, VEC);
    chk("exc_flush_stall", 32'(stall), 32'h0);
    cycle();
    #1; chk("exc_after_flush", 32'(flush), 32'h0); chk("exc_flush_cnt", 32'(flush_cnt), 32'h1);
    cycle();

    // Eret, then eret+exception with exception priority.
    set_in(0, 0, 0, 0, 0, 1, 32'h8000_1234, 0);
    cycle();
    set_in(0, 0, 0, 1, 1, 1, 32'h1111_2222, 0); // requests ignored in FLUSH
    #1; chk("eret_new_pc", new_pc, 32'h8000_1234); chk("eret_flush", 32'(flush), 32'h1);
    chk("flush_ignores_req_stall", 32'(stall), 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cycle();
    set_in(0, 0, 0, 0, 1, 1, 32'h8000_1234, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1; chk("both_new_pc", new_pc, VEC); chk("both_flush", 32'(flush), 32'h1);
    cycle();

    // Deferred exception: stallreq_mem high for 4 cycles.
    set_in(0, 0, 0, 1, 1, 0, 32'h0, 0);
    #1; chk("def_accept_stall", 32'(stall), 32'h3F);
    cycle();
    set_in(0, 0, 0, 1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 3; k++) begin
      #1; chk("def_pend_stall", 32'(stall), 32'h3F); chk("def_pend_flush", 32'(flush), 32'h0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1; chk("def_drop_flush", 32'(flush), 32'h0); chk("def_drop_stall", 32'(stall), 32'h3F);
    cycle();
    #1; chk("def_flush", 32'(flush), 32'h1);
    cycle();
    #1; chk("def_single_pulse", 32'(flush), 32'h0);
    cycle();

    // Reset in the middle of PEND.
    set_in(0, 0, 0, 1, 0, 1, 32'h8000_0040, 0);
    cycle();
    set_in(0, 0, 0, 1, 0, 0, 32'h0, 0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("rstp_flush", 32'(flush), 32'h0);
    chk("rstp_npv", 32'(npv), 32'h0);
    chk("rstp_stall", 32'(stall), 32'h0);
    chk("rstp_new_pc", new_pc, 32'h0);
    chk("rstp_cnt", stall_cnt | 32'(flush_cnt), 32'h0);
    cycle();
    #1; chk("rstp_no_pulse", 32'(flush), 32'h0);
    cycle();

    // Clear takes priority over increment.
    set_in(0, 0, 0, 1, 0, 0, 32'h0, 0);
    repeat (3) cycle();
    set_in(0, 0, 0, 0, 1, 0, 32'h0, 1);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1;
    chk("clr_stall_cnt", stall_cnt, 32'h0);
    chk("clr_flush_cnt", 32'(flush_cnt), 32'h0);
    chk("clr_flush", 32'(flush), 32'h1);
    cycle();

    // Flush counter saturation from a preloaded value.
    force dut.flush_cnt_q = 16'hFFFE;
    #1;
    release dut.flush_cnt_q;
    m_fcnt = 16'hFFFE;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 0, 0, 1, 0, 32'h0, 0);
      cycle();
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 0);
      cycle();
    end
    #1; chk("sat_flush_cnt", 32'(flush_cnt), 32'h0000_FFFF);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             rpc, $urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
